// File: rtl/hex_word_monitor_if.sv
// Bus between a 4-digit 7-segment display source and the hex_word_monitor checker.
// Carries the sampled segment buses in one direction and decoded status the other way.
interface hex_word_monitor_if #(
    parameter int CNT_W = 16
);
    logic             sample_en;
    logic [0:6]       hex3;
    logic [0:6]       hex2;
    logic [0:6]       hex1;
    logic [0:6]       hex0;
    logic [1:0]       code3;
    logic [1:0]       code2;
    logic [1:0]       code1;
    logic [1:0]       code0;
    logic [1:0]       phase;
    logic             locked;
    logic             step;
    logic             err_pat;
    logic             err_seq;
    logic             stall;
    logic [CNT_W-1:0] rot_cnt;
    logic [CNT_W-1:0] err_cnt;

    // Display side: drives the segment buses, observes the checker status.
    modport master (
        output sample_en, hex3, hex2, hex1, hex0,
        input  code3, code2, code1, code0, phase, locked, step,
        input  err_pat, err_seq, stall, rot_cnt, err_cnt
    );

    // Checker side.
    modport slave (
        input  sample_en, hex3, hex2, hex1, hex0,
        output code3, code2, code1, code0, phase, locked, step,
        output err_pat, err_seq, stall, rot_cnt, err_cnt
    );
endinterface

// File: rtl/hex_word_monitor.sv
// hex_word_monitor: decodes four active-low 7-segment buses back to 2-bit character
// codes ('d','E','1',blank), locks onto the rotating "dE1 " word and reports illegal
// glyphs, out-of-order rotation steps and stalls. Outputs lag the hex inputs by 2 clk.
module hex_word_monitor #(
    parameter int CNT_W   = 16,
    parameter int LOCK_N  = 2,
    parameter int STALL_N = 100
) (
    input  logic              clk,
    input  logic              aclr,
    hex_word_monitor_if.slave mon
);
    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam int TMR_W  = $clog2(STALL_N + 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    // {decodable, code}; bit order of seg matches the bus: index 0 = seg a.
    function automatic logic [2:0] decode_seg(input logic [0:6] seg);
        case (seg)
            7'b1000010: decode_seg = 3'b100;
            7'b0110000: decode_seg = 3'b101;
            7'b1001111: decode_seg = 3'b110;
            7'b1111111: decode_seg = 3'b111;
            default:    decode_seg = 3'b000;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + CNT_W'(1);
    endfunction

    // ---- stage 1: capture ----
    logic [0:6] hex3_p1, hex2_p1, hex1_p1, hex0_p1;
    logic       vld_p1;

    // Register the segment buses while sample_en is high; vld_p1 says stage 1 was refreshed.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            hex3_p1 <= 7'h7F;
            hex2_p1 <= 7'h7F;
            hex1_p1 <= 7'h7F;
            hex0_p1 <= 7'h7F;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= mon.sample_en;
            if (mon.sample_en) begin
                hex3_p1 <= mon.hex3;
                hex2_p1 <= mon.hex2;
                hex1_p1 <= mon.hex1;
                hex0_p1 <= mon.hex0;
            end
        end
    end

    logic [2:0]  d3, d2, d1, d0;
    logic [27:0] word_p1;
    logic [27:0] prev_word_p2;
    logic        evt, all_ok, rot_ok;

    assign d3      = decode_seg(hex3_p1);
    assign d2      = decode_seg(hex2_p1);
    assign d1      = decode_seg(hex1_p1);
    assign d0      = decode_seg(hex0_p1);
    assign word_p1 = {hex3_p1, hex2_p1, hex1_p1, hex0_p1};
    assign evt     = (word_p1 != prev_word_p2);
    assign all_ok  = d3[2] & d2[2] & d1[2] & d0[2];
    assign rot_ok  = (d2[1:0] == d3[1:0] + 2'd1) &&
                     (d1[1:0] == d3[1:0] + 2'd2) &&
                     (d0[1:0] == d3[1:0] + 2'd3);

    // ---- stage 2: evaluate ----
    state_t           state_p2;
    logic [GOOD_W-1:0] good_p2;
    logic [TMR_W-1:0]  tmr_p2;
    logic              ref_vld_p2;
    logic [1:0]        code3_p2, code2_p2, code1_p2, code0_p2, phase_p2;
    logic              step_p2, err_pat_p2, err_seq_p2, stall_p2;
    logic [CNT_W-1:0]  rot_cnt_p2, err_cnt_p2;
    logic              step_ok;

    // A rotation step only counts against a phase taken from an earlier legal word.
    assign step_ok = ref_vld_p2 && (d3[1:0] == phase_p2 + 2'd1);

    // Lock FSM, counters, stall timer and pulse outputs, all registered.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_p2     <= HUNT;
            good_p2      <= '0;
            tmr_p2       <= '0;
            ref_vld_p2   <= 1'b0;
            prev_word_p2 <= '1;
            code3_p2     <= 2'd0;
            code2_p2     <= 2'd0;
            code1_p2     <= 2'd0;
            code0_p2     <= 2'd0;
            phase_p2     <= 2'd0;
            step_p2      <= 1'b0;
            err_pat_p2   <= 1'b0;
            err_seq_p2   <= 1'b0;
            stall_p2     <= 1'b0;
            rot_cnt_p2   <= '0;
            err_cnt_p2   <= '0;
        end else begin
            step_p2    <= 1'b0;
            err_pat_p2 <= 1'b0;
            err_seq_p2 <= 1'b0;
            if (evt) begin
                prev_word_p2 <= word_p1;
                tmr_p2       <= '0;
                stall_p2     <= 1'b0;
                if (!all_ok || !rot_ok) begin
                    // Not a rotation word: pattern error wins over sequence error.
                    err_pat_p2 <= !all_ok;
                    err_seq_p2 <= all_ok;
                    err_cnt_p2 <= sat_inc(err_cnt_p2);
                    state_p2   <= HUNT;
                    good_p2    <= '0;
                    ref_vld_p2 <= 1'b0;
                end else begin
                    code3_p2   <= d3[1:0];
                    code2_p2   <= d2[1:0];
                    code1_p2   <= d1[1:0];
                    code0_p2   <= d0[1:0];
                    phase_p2   <= d3[1:0];
                    ref_vld_p2 <= 1'b1;
                    if (step_ok) begin
                        step_p2    <= 1'b1;
                        rot_cnt_p2 <= rot_cnt_p2 + CNT_W'(1);
                        if (state_p2 == HUNT) begin
                            good_p2 <= good_p2 + GOOD_W'(1);
                            if (good_p2 + GOOD_W'(1) == GOOD_W'(LOCK_N)) begin
                                state_p2 <= LOCKED;
                            end
                        end
                    end else begin
                        good_p2 <= '0;
                        if (state_p2 == LOCKED) begin
                            err_seq_p2 <= 1'b1;
                            err_cnt_p2 <= sat_inc(err_cnt_p2);
                            state_p2   <= HUNT;
                        end
                    end
                end
            end else if (state_p2 == LOCKED && vld_p1) begin
                // Quiet cycles only count while stage 1 is actually being refreshed.
                if (tmr_p2 != TMR_W'(STALL_N)) begin
                    tmr_p2 <= tmr_p2 + TMR_W'(1);
                end
                if (tmr_p2 == TMR_W'(STALL_N - 1)) begin
                    stall_p2 <= 1'b1;
                end
            end
        end
    end

    assign mon.code3   = code3_p2;
    assign mon.code2   = code2_p2;
    assign mon.code1   = code1_p2;
    assign mon.code0   = code0_p2;
    assign mon.phase   = phase_p2;
    assign mon.locked  = (state_p2 == LOCKED);
    assign mon.step    = step_p2;
    assign mon.err_pat = err_pat_p2;
    assign mon.err_seq = err_seq_p2;
    assign mon.stall   = stall_p2;
    assign mon.rot_cnt = rot_cnt_p2;
    assign mon.err_cnt = err_cnt_p2;
endmodule

// File: tb/tb_hex_word_monitor.sv
// Bench for hex_word_monitor: two instances (16-bit and 2-bit counters) share one
// directed stimulus; a word-level model predicts every output each cycle.
module tb_hex_word_monitor;
    localparam int LOCK_N  = 2;
    localparam int STALL_N = 100;

    logic clk = 1'b0;
    logic aclr = 1'b0;
    logic t_en = 1'b0;
    logic [0:6] t_hex [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hex_word_monitor_if #(.CNT_W(16)) bus ();
    hex_word_monitor_if #(.CNT_W(2))  bus_s ();

    assign bus.sample_en   = t_en;
    assign bus.hex3        = t_hex[0];
    assign bus.hex2        = t_hex[1];
    assign bus.hex1        = t_hex[2];
    assign bus.hex0        = t_hex[3];
    assign bus_s.sample_en = t_en;
    assign bus_s.hex3      = t_hex[0];
    assign bus_s.hex2      = t_hex[1];
    assign bus_s.hex1      = t_hex[2];
    assign bus_s.hex0      = t_hex[3];

    hex_word_monitor #(.CNT_W(16), .LOCK_N(LOCK_N), .STALL_N(STALL_N)) dut (
        .clk(clk), .aclr(aclr), .mon(bus.slave)
    );
    hex_word_monitor #(.CNT_W(2), .LOCK_N(LOCK_N), .STALL_N(STALL_N)) dut_s (
        .clk(clk), .aclr(aclr), .mon(bus_s.slave)
    );

    // Character glyphs on an active-low bus, index 0 = seg a.
    function automatic logic [0:6] seg_of(input int c);
        case (c)
            0:       seg_of = 7'b1000010;
            1:       seg_of = 7'b0110000;
            2:       seg_of = 7'b1001111;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    function automatic int chr(input logic [0:6] s);
        if (s == 7'b1000010) return 0;
        if (s == 7'b0110000) return 1;
        if (s == 7'b1001111) return 2;
        if (s == 7'b1111111) return 3;
        return -1;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- word-level model ----------------
    logic [0:6] m_cap [4];
    logic [0:6] m_last [4];
    bit m_en_d;
    int m_code [4];
    int m_phase, m_good, m_rot, m_err, m_quiet;
    bit m_locked, m_ref, m_step, m_pat, m_seq, m_stall;

    always @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            for (int i = 0; i < 4; i++) begin
                m_cap[i] = 7'h7F; m_last[i] = 7'h7F; m_code[i] = 0;
            end
            m_en_d = 0; m_phase = 0; m_good = 0; m_rot = 0; m_err = 0; m_quiet = 0;
            m_locked = 0; m_ref = 0; m_step = 0; m_pat = 0; m_seq = 0; m_stall = 0;
        end else begin
            int c [4];
            bit changed, bad_glyph, not_rot;
            m_step = 0; m_pat = 0; m_seq = 0;
            changed = 0;
            for (int i = 0; i < 4; i++) if (m_cap[i] != m_last[i]) changed = 1;
            if (changed) begin
                bad_glyph = 0; not_rot = 0;
                for (int i = 0; i < 4; i++) begin
                    m_last[i] = m_cap[i];
                    c[i] = chr(m_cap[i]);
                    if (c[i] < 0) bad_glyph = 1;
                end
                for (int i = 1; i < 4; i++) if (c[i] != (c[0] + i) % 4) not_rot = 1;
                m_quiet = 0;
                if (bad_glyph || not_rot) begin
                    m_pat = bad_glyph; m_seq = !bad_glyph;
                    m_err++; m_locked = 0; m_good = 0; m_ref = 0;
                end else begin
                    bit adv;
                    adv = m_ref && (c[0] == (m_phase + 1) % 4);
                    for (int i = 0; i < 4; i++) m_code[i] = c[i];
                    m_phase = c[0]; m_ref = 1;
                    if (adv) begin
                        m_step = 1; m_rot++;
                        if (!m_locked) begin
                            m_good++;
                            if (m_good >= LOCK_N) m_locked = 1;
                        end
                    end else begin
                        m_good = 0;
                        if (m_locked) begin m_seq = 1; m_err++; m_locked = 0; end
                    end
                end
            end else if (m_locked && m_en_d) begin
                m_quiet++;
            end
            m_stall = m_locked && (m_quiet >= STALL_N);
            if (t_en) for (int i = 0; i < 4; i++) m_cap[i] = t_hex[i];
            m_en_d = t_en;
        end
    end

    // Every cycle out of reset, both instances must match the model.
    always @(negedge clk) begin
        if (aclr) begin
            cmp("code3",   bus.code3,   m_code[0]);
            cmp("code2",   bus.code2,   m_code[1]);
            cmp("code1",   bus.code1,   m_code[2]);
            cmp("code0",   bus.code0,   m_code[3]);
            cmp("phase",   bus.phase,   m_phase);
            cmp("locked",  bus.locked,  m_locked);
            cmp("step",    bus.step,    m_step);
            cmp("err_pat", bus.err_pat, m_pat);
            cmp("err_seq", bus.err_seq, m_seq);
            cmp("stall",   bus.stall,   m_stall);
            cmp("rot_cnt", bus.rot_cnt, m_rot % 65536);
            cmp("err_cnt", bus.err_cnt, (m_err > 65535) ? 65535 : m_err);
            cmp("s_locked",  bus_s.locked,  m_locked);
            cmp("s_step",    bus_s.step,    m_step);
            cmp("s_err_pat", bus_s.err_pat, m_pat);
            cmp("s_err_seq", bus_s.err_seq, m_seq);
            cmp("s_stall",   bus_s.stall,   m_stall);
            cmp("s_rot_cnt", bus_s.rot_cnt, m_rot % 4);
            cmp("s_err_cnt", bus_s.err_cnt, (m_err > 3) ? 3 : m_err);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_word(input int ph);
        for (int i = 0; i < 4; i++) t_hex[i] = seg_of((ph + i) % 4);
    endtask

    task automatic put_word(input int ph, input int n);
        set_word(ph);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) t_hex[i] = 7'h7F;
        repeat (3) @(negedge clk);
        cmp("reset_rot",    bus.rot_cnt, 0);
        cmp("reset_locked", bus.locked,  0);
        aclr = 1'b1;
        t_en = 1'b1;

        // 1: clean rotation locks after the second step
        put_word(0, 10);
        put_word(1, 10);
        put_word(2, 10);
        cmp("t1_locked_after_2", bus.locked, 1);
        put_word(3, 10);
        put_word(0, 10);
        cmp("t1_rot", bus.rot_cnt, 4);
        cmp("t1_phase", bus.phase, 0);
        cmp("t1_err", bus.err_cnt, 0);

        // 2: illegal glyph on hex2 while locked at phase 0
        set_word(0);
        t_hex[1] = 7'b0000000;
        repeat (10) @(negedge clk);
        cmp("t2_err_cnt", bus.err_cnt, 1);
        cmp("t2_locked", bus.locked, 0);
        cmp("t2_code3", bus.code3, 0);
        cmp("t2_code0", bus.code0, 3);
        put_word(1, 10);
        put_word(2, 10);
        put_word(3, 10);
        put_word(0, 10);
        put_word(1, 10);
        cmp("t2_relock_rot", bus.rot_cnt, 8);

        // 3: skip from phase 1 to phase 3, then re-lock
        put_word(3, 10);
        cmp("t3_err_cnt", bus.err_cnt, 2);
        cmp("t3_hunt", bus.locked, 0);
        put_word(0, 10);
        put_word(1, 10);
        cmp("t3_relock", bus.locked, 1);
        cmp("t3_rot", bus.rot_cnt, 10);

        // 4: static word until stall, then one more step clears it
        set_word(2);
        repeat (2) @(negedge clk);
        cmp("t4_step", bus.step, 1);
        repeat (STALL_N - 1) @(negedge clk);
        cmp("t4_no_stall_yet", bus.stall, 0);
        @(negedge clk);
        cmp("t4_stall", bus.stall, 1);
        set_word(3);
        repeat (2) @(negedge clk);
        cmp("t4_stall_clear", bus.stall, 0);
        cmp("t4_step2", bus.step, 1);
        repeat (5) @(negedge clk);

        // 5: capture disabled while inputs change
        t_en = 1'b0;
        put_word(0, 30);
        cmp("t5_rot_frozen", bus.rot_cnt, 12);
        cmp("t5_still_locked", bus.locked, 1);
        t_en = 1'b1;
        repeat (2) @(negedge clk);
        cmp("t5_resume_step", bus.step, 1);
        repeat (8) @(negedge clk);

        // extra errors: bad glyph on hex0, then an all-blank word
        set_word(1);
        t_hex[3] = 7'b0000000;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) t_hex[i] = 7'h7F;
        repeat (10) @(negedge clk);
        cmp("sat_err_big", bus.err_cnt, 4);
        cmp("sat_err_small", bus_s.err_cnt, 3);

        // 6: asynchronous reset mid-run, then 5 steps wrap the 2-bit counter
        #2 aclr = 1'b0;
        #1;
        cmp("t6_rst_rot", bus.rot_cnt, 0);
        cmp("t6_rst_err", bus.err_cnt, 0);
        cmp("t6_rst_locked", bus.locked, 0);
        cmp("t6_rst_s_err", bus_s.err_cnt, 0);
        repeat (3) @(negedge clk);
        aclr = 1'b1;
        for (int p = 0; p < 6; p++) put_word(p % 4, 10);
        cmp("t6_rot_big", bus.rot_cnt, 5);
        cmp("t6_rot_wrap", bus_s.rot_cnt, 1);
        cmp("t6_phase", bus.phase, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
